pe_switch_reader: RTL and testbench
===================================

Name: pe_switch_reader

Overview:
Memory-mapped input peripheral, the read-side counterpart to the LED output register on the same peripheral bus. It samples 24 board switches and 5 push-buttons through a 2-flop synchroniser and debounce logic. It keeps sticky press-event flags for the buttons and returns registered read data to the CPU on a 12-bit peripheral address decode. It sits beside the LED peripheral in the SoC bridge; the bridge ORs `rdata` with the other peripherals' read data.

Parameters:
- SW_ADDR, 12'h070, read address of the switch register
- BTN_ADDR, 12'h078, read address of the button register
- DB_CYCLES, 50000, consecutive stable cycles required to accept a new input value (legal range 2..65535)
- DB_CNT_W, 16, width of each debounce counter; must satisfy 2^DB_CNT_W > DB_CYCLES

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- addr  input  12  peripheral byte address
- ren  input  1  read enable, single-cycle strobe
- sw  input  24  raw switch pins, asynchronous
- btn  input  5  raw button pins, asynchronous, 1 = pressed
- rdata  output  32  read data, registered
- irq  output  1  present only with SW_IRQ_EN

Behaviour:
- Reset (async, rst=1): sync flops, stable values, counters, event flags, `rdata` all to 0; `irq` = 0.
- Synchroniser: `sw` and `btn` each pass through 2 flops, giving `sw_s` and `btn_s`.
- Debounce: two independent group counters, one for `sw_s` vs `sw_stable` and one for `btn_s` vs `btn_stable`.
  - Mismatch: counter increments each cycle.
  - Match: counter clears to 0.
  - Mismatch while counter == DB_CYCLES-1: stable <= synced value and counter <= 0 on that edge.
  - A glitch shorter than DB_CYCLES cycles never reaches stable.
  - A new mismatch value mid-count does not restart the count; only a return to match clears it.
- Pin-to-stable latency: DB_CYCLES+2 clocks.
- Button events: `btn_evt[i]` is set on the cycle `btn_stable[i]` goes 0->1; it stays set until cleared.
- Read: on posedge with ren=1, `rdata` is loaded, so data is valid the cycle after the strobe (1-cycle latency).
  - addr==SW_ADDR: rdata = {8'h0, sw_stable}.
  - addr==BTN_ADDR: rdata = {19'h0, btn_evt[4:0] at [12:8], 3'b0, btn_stable[4:0] at [4:0]}.
  - Any other addr, or ren=0: rdata <= 0.
  - Returned values are pre-edge values of stable/evt.
- Read-to-clear: a read of BTN_ADDR clears all `btn_evt` bits on the same edge.
  - If a new rising edge sets bit i on that same edge, bit i stays 1 (set wins), and the read returns the old value.
- Reads of SW_ADDR have no side effects.
- No write path; `addr` matches with ren=0 are ignored.
- Reset mid-debounce: counters clear and stable returns to 0. After release, the full DB_CYCLES count is required again; a switch held at 1 through reset reaches stable at DB_CYCLES+2 clocks after release.

Optional Feature:
- Macro SW_IRQ_EN.
- Defined: output `irq` = registered OR of `btn_evt[4:0]`, i.e. 1 cycle after any flag sets. It drops the cycle after a clearing read, unless a flag was re-set on that edge.
- Undefined: `irq` port and its register are absent; everything else is identical.

Test Plan (bench uses DB_CYCLES=4):
- Reset: assert rst asynchronously mid-cycle, then read both addresses -> rdata=0; `irq`=0.
- Switch accept: set sw=24'hA5A5A5 and hold. A read at clock 5 after the pin change returns 0; a read at clock 6 or later returns 32'h00A5A5A5.
- Glitch reject: pulse sw[0]=1 for 3 clocks, then return to 0 -> repeated reads of SW_ADDR always return 0.
- Button event/clear: press btn[2] and hold, read BTN_ADDR -> 32'h00000404. Read again -> 32'h00000004. Release and wait 6 clocks -> read returns 0.
- Set-wins collision: btn[1] becomes stable on the same edge as a BTN_ADDR read -> that read returns bit 9 = 0; the next read returns bit 9 = 1.
- Unmapped/no-enable: ren=1 with addr=12'h060, and ren=0 with addr=SW_ADDR -> rdata=0; event flags are unchanged.

Source files
------------

// File: rtl/pe_switch_reader.sv
`default_nettype none
// ============================================================================
// Module   : pe_switch_reader
// Purpose  : Memory-mapped input peripheral. It samples 24 board switches and
//            5 push-buttons through a 2-flop synchroniser and group debounce,
//            and keeps sticky press-event flags for the buttons. The flags are
//            cleared when the button register is read. Read data is
//            registered, and is driven to zero when this block is not
//            selected so that the bridge can OR it with other peripherals.
// Ports    : clk   - system clock
//            rst   - asynchronous active-high reset
//            addr  - 12-bit peripheral byte address
//            ren   - single-cycle read strobe
//            sw    - raw switch pins (asynchronous)
//            btn   - raw button pins (asynchronous, 1 = pressed)
//            rdata - registered read data, valid the cycle after ren
//            irq   - OR of button event flags (only with SW_IRQ_EN)
// Options  : `define SW_IRQ_EN adds the registered irq output.
// Revision : 1.0 - initial release
// ============================================================================
module pe_switch_reader #(
    parameter logic [11:0] SW_ADDR   = 12'h070,
    parameter logic [11:0] BTN_ADDR  = 12'h078,
    parameter int          DB_CYCLES = 50000,  // 2..65535
    parameter int          DB_CNT_W  = 16      // 2**DB_CNT_W > DB_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] addr,
    input  logic        ren,
    input  logic [23:0] sw,
    input  logic [4:0]  btn,
    output logic [31:0] rdata
`ifdef SW_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam logic [DB_CNT_W-1:0] c_db_last = DB_CNT_W'(DB_CYCLES - 1);
    localparam logic [DB_CNT_W-1:0] c_one     = DB_CNT_W'(1);

    // Synchroniser stages
    logic [23:0] sw_m_q, sw_s_q;
    logic [4:0]  btn_m_q, btn_s_q;

    // Debounce state
    logic [23:0]         sw_stable_q, sw_stable_d;
    logic [4:0]          btn_stable_q, btn_stable_d;
    logic [DB_CNT_W-1:0] sw_cnt_q, sw_cnt_d;
    logic [DB_CNT_W-1:0] btn_cnt_q, btn_cnt_d;

    // Events and read port
    logic [4:0]  btn_evt_q, btn_evt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        btn_clr;

    // Group debounce: any difference between synced and stable value keeps
    // the counter running, even if the synced value changes again mid-count.
    // Only a full return to match clears it.
    always_comb begin
        sw_stable_d = sw_stable_q;
        sw_cnt_d    = '0;
        if (sw_s_q != sw_stable_q) begin
            if (sw_cnt_q == c_db_last) begin
                sw_stable_d = sw_s_q;
            end else begin
                sw_cnt_d = sw_cnt_q + c_one;
            end
        end
    end

    always_comb begin
        btn_stable_d = btn_stable_q;
        btn_cnt_d    = '0;
        if (btn_s_q != btn_stable_q) begin
            if (btn_cnt_q == c_db_last) begin
                btn_stable_d = btn_s_q;
            end else begin
                btn_cnt_d = btn_cnt_q + c_one;
            end
        end
    end

    // A button-register read clears all flags, but a rising edge of the
    // debounced button on the same clock sets its flag anyway (set wins).
    assign btn_clr = ren && (addr == BTN_ADDR);

    always_comb begin
        btn_evt_d = (btn_evt_q & ~{5{btn_clr}}) | (btn_stable_d & ~btn_stable_q);
    end

    // Read mux uses pre-edge stable/event values.
    always_comb begin
        rdata_d = '0;
        if (ren) begin
            if (addr == SW_ADDR) begin
                rdata_d = {8'h00, sw_stable_q};
            end else if (addr == BTN_ADDR) begin
                rdata_d = {19'h0, btn_evt_q, 3'b000, btn_stable_q};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_m_q       <= '0;
            sw_s_q       <= '0;
            btn_m_q      <= '0;
            btn_s_q      <= '0;
            sw_stable_q  <= '0;
            btn_stable_q <= '0;
            sw_cnt_q     <= '0;
            btn_cnt_q    <= '0;
            btn_evt_q    <= '0;
            rdata_q      <= '0;
        end else begin
            sw_m_q       <= sw;
            sw_s_q       <= sw_m_q;
            btn_m_q      <= btn;
            btn_s_q      <= btn_m_q;
            sw_stable_q  <= sw_stable_d;
            btn_stable_q <= btn_stable_d;
            sw_cnt_q     <= sw_cnt_d;
            btn_cnt_q    <= btn_cnt_d;
            btn_evt_q    <= btn_evt_d;
            rdata_q      <= rdata_d;
        end
    end

    assign rdata = rdata_q;

`ifdef SW_IRQ_EN
    // Registered from the flag register: rises one cycle after a flag sets
    // and falls one cycle after a clearing read.
    logic irq_q, irq_d;

    always_comb begin
        irq_d = |btn_evt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pe_switch_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_switch_reader
// Purpose  : Directed self-checking bench for pe_switch_reader with
//            DB_CYCLES = 4. Expected values are hand-computed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_switch_reader;

    localparam logic [11:0] c_sw_addr  = 12'h070;
    localparam logic [11:0] c_btn_addr = 12'h078;

    logic        clk;
    logic        rst;
    logic [11:0] addr;
    logic        ren;
    logic [23:0] sw;
    logic [4:0]  btn;
    logic [31:0] rdata;
`ifdef SW_IRQ_EN
    logic        irq;
`endif

    int n_vec;
    int n_err;

    pe_switch_reader #(
        .SW_ADDR   (c_sw_addr),
        .BTN_ADDR  (c_btn_addr),
        .DB_CYCLES (4),
        .DB_CNT_W  (4)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .ren   (ren),
        .sw    (sw),
        .btn   (btn),
        .rdata (rdata)
`ifdef SW_IRQ_EN
        ,
        .irq   (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One bus cycle: strobe on the next edge, then check the registered data.
    task automatic bus_rd(input logic [11:0] a, input logic r, input logic [31:0] exp,
                          input string tag);
        addr = a;
        ren  = r;
        @(posedge clk);
        #1;
        ren  = 1'b0;
        check(tag, rdata, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        addr  = '0;
        ren   = 1'b0;
        sw    = '0;
        btn   = '0;

        // Asynchronous reset between edges: outputs must clear with no edge.
        #3 rst = 1'b1;
        #1;
        check("rst_async_rdata", rdata, 32'h0);
`ifdef SW_IRQ_EN
        check("rst_async_irq", {31'h0, irq}, 32'h0);
`endif
        idle(2);
        rst = 1'b0;
        bus_rd(c_sw_addr,  1'b1, 32'h0, "rst_sw_rd");
        bus_rd(c_btn_addr, 1'b1, 32'h0, "rst_btn_rd");

        // Glitch: 3 clocks high never survives a 4-cycle debounce.
        sw = 24'h000001;
        for (int i = 0; i < 3; i++) bus_rd(c_sw_addr, 1'b1, 32'h0, "glitch_hi");
        sw = 24'h000000;
        for (int i = 0; i < 8; i++) bus_rd(c_sw_addr, 1'b1, 32'h0, "glitch_lo");

        // Accept: first edge after the pin change is clock 0; stable updates
        // on clock 5, so a strobe at clock 5 sees 0 and clock 6 sees the value.
        sw = 24'hA5A5A5;
        idle(5);
        bus_rd(c_sw_addr, 1'b1, 32'h0,        "sw_clk5");
        bus_rd(c_sw_addr, 1'b1, 32'h00A5A5A5, "sw_clk6");

        // Button event and read-to-clear.
        btn = 5'b00100;
        idle(8);
`ifdef SW_IRQ_EN
        check("irq_set", {31'h0, irq}, 32'h1);
`endif
        bus_rd(c_btn_addr, 1'b1, 32'h00000404, "btn2_evt");
        bus_rd(c_btn_addr, 1'b1, 32'h00000004, "btn2_cleared");
`ifdef SW_IRQ_EN
        check("irq_clear", {31'h0, irq}, 32'h0);
`endif
        btn = 5'b00000;
        idle(6);
        bus_rd(c_btn_addr, 1'b1, 32'h0, "btn2_release");

        // Set-wins: btn[1] becomes stable on clock 5, the same edge as the read.
        btn = 5'b00010;
        idle(5);
        bus_rd(c_btn_addr, 1'b1, 32'h00000000, "collide_old");
        bus_rd(c_btn_addr, 1'b1, 32'h00000202, "collide_set");
        bus_rd(c_btn_addr, 1'b1, 32'h00000002, "collide_clr");

        // Unmapped address and ren=0 give 0 and leave flags alone.
        btn = 5'b10010;
        idle(8);
        bus_rd(12'h060,    1'b1, 32'h0,        "unmapped");
        bus_rd(c_sw_addr,  1'b0, 32'h0,        "sw_no_ren");
        bus_rd(c_btn_addr, 1'b0, 32'h0,        "btn_no_ren");
        bus_rd(c_btn_addr, 1'b1, 32'h00001012, "evt_kept");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
